pulse_sequencer: RTL

Spin-echo pulse programme controller for the spectrometer's transmit/receive datapath. On a start request it sequences pre-blank, 90° pulse, echo gap, 180° pulse, echo gap and record window. It drives the TX DDS gate and phase, the amplifier unblank line and the RX capture enable. It sits between the host-written configuration registers and the `operations` datapath, replacing free-running pulse timing with a single arbitrated, abortable state machine.

---
 rtl/nmr_seq_pkg.sv | 40 ++++
 rtl/seg_counter.sv | 39 +++
 rtl/pulse_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/nmr_seq_pkg.sv
// Shared types, default parameters and helpers for the spin-echo pulse sequencer.
package nmr_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StP90,
      StGap1,
      StP180,
      StGap2,
      StRec
   } seq_state_t;

   localparam int unsigned DefCntW        = 32;
   localparam int unsigned DefPhaseW      = 5;
   localparam int unsigned DefUblankLead  = 4;
   localparam int unsigned DefPhase180Ofs = 8;

   // Programme order; REC hands back to IDLE.
   function automatic seq_state_t next_seg(input seq_state_t s);
      seq_state_t n;
      case (s)
         StPre:   n = StP90;
         StP90:   n = StGap1;
         StGap1:  n = StP180;
         StP180:  n = StGap2;
         StGap2:  n = StRec;
         default: n = StIdle;
      endcase
      return n;
   endfunction

   function automatic logic [31:0] phase_add(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned w);
      logic [31:0] mask;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (a + b) & mask;
   endfunction

endpackage

// File: rtl/seg_counter.sv
// Loadable down-counter shared by every segment of the pulse programme.
module seg_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_len,
   output logic             o_zero_len,
   output logic             o_last,
   output logic [CNT_W-1:0] o_cnt_nxt
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;

   assign o_zero_len = (i_len == '0);
   assign o_last     = (r_cnt == '0);
   assign o_cnt_nxt  = w_cnt_d;

   // Loading len-1 makes a length L occupy exactly L cycles, ending on o_last.
   always_comb begin
      w_cnt_d = r_cnt;
      if (i_load) begin
         w_cnt_d = o_zero_len ? '0 : i_len - CNT_W'(1);
      end else if (!o_last) begin
         w_cnt_d = r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

endmodule

// File: rtl/pulse_sequencer.sv
// Spin-echo programme controller: pre-blank, 90, gap, 180, gap, record; abortable.
module pulse_sequencer
   import nmr_seq_pkg::*;
#(
   parameter int unsigned CNT_W         = DefCntW,
   parameter int unsigned PHASE_W       = DefPhaseW,
   parameter int unsigned UBLANK_LEAD   = DefUblankLead,
   parameter int unsigned PHASE_180_OFS = DefPhase180Ofs
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable_PC,
   input  logic [CNT_W-1:0]   pulse_90_len,
   input  logic [CNT_W-1:0]   pulse_180_len,
   input  logic [CNT_W-1:0]   pulse_gap_data,
   input  logic [CNT_W-1:0]   record_len_data,
   input  logic [PHASE_W-1:0] tx_phase_data,
   output logic               tx_en,
   output logic [PHASE_W-1:0] tx_phase,
   output logic               u_blank,
   output logic               rx_en,
   output logic               busy,
   output logic               done
);

   seq_state_t         r_state;
   seq_state_t         w_nxt;
   logic               r_en_prev;
   logic               r_start;
   logic [CNT_W-1:0]   r_l90, r_l180, r_gap, r_lrec;
   logic [PHASE_W-1:0] r_base;
   logic               r_tx_en, r_u_blank, r_rx_en, r_busy, r_done;
   logic [PHASE_W-1:0] r_tx_phase;

   logic               w_start;
   logic               w_complete;
   logic               w_idle;
   logic [CNT_W-1:0]   w_l90, w_l180, w_gap, w_lrec;
   logic [PHASE_W-1:0] w_base;
   logic [PHASE_W-1:0] w_phase_180;
   logic [CNT_W-1:0]   w_load_len;
   logic               w_load;
   logic               w_zero_len;
   logic               w_last;
   logic [CNT_W-1:0]   w_cnt_nxt;

   function automatic logic [CNT_W-1:0] len_of(input seq_state_t s,
                                              input logic [CNT_W-1:0] l90,
                                              input logic [CNT_W-1:0] l180,
                                              input logic [CNT_W-1:0] gap,
                                              input logic [CNT_W-1:0] lrec);
      logic [CNT_W-1:0] l;
      case (s)
         StPre:          l = CNT_W'(UBLANK_LEAD);
         StP90:          l = l90;
         StGap1, StGap2: l = gap;
         StP180:         l = l180;
         StRec:          l = lrec;
         default:        l = '0;
      endcase
      return l;
   endfunction

   // Walk forward past zero-length segments so they occupy no cycles at all.
   function automatic seq_state_t first_nz(input seq_state_t s0,
                                           input logic [CNT_W-1:0] l90,
                                           input logic [CNT_W-1:0] l180,
                                           input logic [CNT_W-1:0] gap,
                                           input logic [CNT_W-1:0] lrec);
      seq_state_t s;
      s = s0;
      for (int i = 0; i < 6; i++) begin
         if (s != StIdle && len_of(s, l90, l180, gap, lrec) == '0) begin
            s = next_seg(s);
         end
      end
      return s;
   endfunction

   // In IDLE the live inputs are what gets latched on this edge.
   assign w_idle  = (r_state == StIdle);
   assign w_l90   = w_idle ? pulse_90_len    : r_l90;
   assign w_l180  = w_idle ? pulse_180_len   : r_l180;
   assign w_gap   = w_idle ? pulse_gap_data  : r_gap;
   assign w_lrec  = w_idle ? record_len_data : r_lrec;
   assign w_base  = w_idle ? tx_phase_data   : r_base;
   assign w_start = r_start & enable_PC;

   assign w_phase_180 = PHASE_W'(phase_add(32'(w_base), 32'(PHASE_180_OFS), PHASE_W));

   always_comb begin
      w_nxt      = r_state;
      w_complete = 1'b0;
      if (w_idle) begin
         if (w_start) begin
            w_nxt      = first_nz(StPre, w_l90, w_l180, w_gap, w_lrec);
            w_complete = (w_nxt == StIdle);
         end
      end else if (!enable_PC) begin
         w_nxt = StIdle;
      end else if (w_last) begin
         w_nxt      = first_nz(next_seg(r_state), w_l90, w_l180, w_gap, w_lrec);
         w_complete = (w_nxt == StIdle);
      end
   end

   assign w_load_len = len_of(w_nxt, w_l90, w_l180, w_gap, w_lrec);
   assign w_load     = (w_nxt != r_state) && !w_zero_len;

   seg_counter #(
      .CNT_W (CNT_W)
   ) u_seg_counter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_len      (w_load_len),
      .o_zero_len (w_zero_len),
      .o_last     (w_last),
      .o_cnt_nxt  (w_cnt_nxt)
   );

   always_ff @(posedge clk) begin
      // Tracking enable during reset stops a held-high enable from looking like an edge.
      r_en_prev <= enable_PC;
      if (rst) begin
         r_start    <= 1'b0;
         r_state    <= StIdle;
         r_l90      <= '0;
         r_l180     <= '0;
         r_gap      <= '0;
         r_lrec     <= '0;
         r_base     <= '0;
         r_tx_en    <= 1'b0;
         r_u_blank  <= 1'b0;
         r_rx_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_tx_phase <= '0;
      end else begin
         r_start <= enable_PC & ~r_en_prev;
         r_state <= w_nxt;
         if (w_idle && w_start) begin
            r_l90  <= pulse_90_len;
            r_l180 <= pulse_180_len;
            r_gap  <= pulse_gap_data;
            r_lrec <= record_len_data;
            r_base <= tx_phase_data;
         end
         r_busy    <= (w_nxt != StIdle);
         r_tx_en   <= (w_nxt == StP90) || (w_nxt == StP180);
         r_rx_en   <= (w_nxt == StRec);
         r_done    <= w_complete;
         r_u_blank <= (w_nxt == StPre) || (w_nxt == StP90) || (w_nxt == StP180) ||
                      ((w_nxt == StGap1) && (w_cnt_nxt < CNT_W'(UBLANK_LEAD)));
         case (w_nxt)
            StIdle:  r_tx_phase <= '0;
            StP90:   r_tx_phase <= w_base;
            StP180:  r_tx_phase <= w_phase_180;
            default: r_tx_phase <= r_tx_phase;
         endcase
      end
   end

   assign tx_en    = r_tx_en;
   assign tx_phase = r_tx_phase;
   assign u_blank  = r_u_blank;
   assign rx_en    = r_rx_en;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
